apb_prio_master: RTL

- APB initiator that programs and reads back the interrupt controller's priority registers on behalf of the processor/firmware sequencer.
- Accepts single read/write commands on a valid/ready interface and runs each as one APB transfer (SETUP then ACCESS).
- Waits for pready with a bounded timeout, then returns a one-cycle response pulse.
- Sits between the processor command path and the interrupt controller's APB slave port.

---
 rtl/apb_prio_master.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_prio_master.sv
// APB initiator for the interrupt controller priority registers: one command, one APB transfer, one response pulse.
// Optional power-up programming of every priority register is enabled by defining APB_PRIO_AUTO_INIT_EN.
module apb_prio_master #(
  parameter int unsigned NO_OF_PERIPHERALS = 8,
  parameter int unsigned WIDTH             = $clog2(NO_OF_PERIPHERALS),
  parameter int unsigned TIMEOUT_CYCLES    = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             init_busy,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [WIDTH-1:0] paddr,
  output logic [WIDTH-1:0] pwdata,
  input  logic [WIDTH-1:0] prdata,
  input  logic             pready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_INIT   = 2'd3
  } state_t;

`ifdef APB_PRIO_AUTO_INIT_EN
  localparam state_t RST_STATE = S_INIT;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_cmd_ready, w_cmd_ready_nxt;
  logic               r_psel, w_psel_nxt;
  logic               r_penable, w_penable_nxt;
  logic               r_pwrite, w_pwrite_nxt;
  logic [WIDTH-1:0]   r_paddr, w_paddr_nxt;
  logic [WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;

  logic w_accept;
  logic w_timeout;
  logic w_done;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
  assign w_timeout = (r_state == S_ACCESS) && !pready && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_done    = (r_state == S_ACCESS) && (pready || w_timeout);

`ifdef APB_PRIO_AUTO_INIT_EN
  logic             r_init_busy, w_init_busy_nxt;
  logic [WIDTH-1:0] r_idx, w_idx_nxt;
  logic             w_last;

  assign w_last = (r_idx == WIDTH'(NO_OF_PERIPHERALS - 1));
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= RST_STATE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
`ifdef APB_PRIO_AUTO_INIT_EN
          if (r_init_busy && !w_last) w_state_nxt = S_INIT;
`endif
        end
      end
`ifdef APB_PRIO_AUTO_INIT_EN
      S_INIT:   w_state_nxt = S_SETUP;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and timeout counter
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = r_cmd_ready;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
`ifdef APB_PRIO_AUTO_INIT_EN
    w_init_busy_nxt = r_init_busy;
    w_idx_nxt       = r_idx;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
          w_pwrite_nxt    = cmd_write;
          w_paddr_nxt     = cmd_addr;
          w_pwdata_nxt    = cmd_wdata;
          w_cnt_nxt       = '0;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        if (w_done) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = 1'b0;
          w_paddr_nxt   = '0;
          w_pwdata_nxt  = '0;
          w_cnt_nxt     = '0;
`ifdef APB_PRIO_AUTO_INIT_EN
          if (r_init_busy) begin
            // Init writes never respond; a timed-out index is simply skipped
            if (w_last) begin
              w_init_busy_nxt = 1'b0;
              w_cmd_ready_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + WIDTH'(1);
            end
          end else
`endif
          begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = !pready;
            w_rsp_rdata_nxt = (pready && !r_pwrite) ? prdata : '0;
            w_cmd_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef APB_PRIO_AUTO_INIT_EN
      S_INIT: begin
        w_init_busy_nxt = 1'b1;
        w_cmd_ready_nxt = 1'b0;
        w_psel_nxt      = 1'b1;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = 1'b1;
        w_paddr_nxt     = r_idx;
        w_pwdata_nxt    = r_idx;
        w_cnt_nxt       = '0;
      end
`endif
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_PRIO_AUTO_INIT_EN
      r_init_busy <= 1'b0;
      r_idx       <= '0;
`endif
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`ifdef APB_PRIO_AUTO_INIT_EN
      r_init_busy <= w_init_busy_nxt;
      r_idx       <= w_idx_nxt;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
`ifdef APB_PRIO_AUTO_INIT_EN
  assign init_busy = r_init_busy;
`else
  assign init_busy = 1'b0;
`endif

endmodule
